// File: rtl/freq_period_meter_pkg.sv
// Shared types and defaults for the oscillator period meter and its consumers.
//   DATA_BITS_DEF       default sample / cycle-counter width
//   PERIOD_BITS_DEF     default window length exponent (2^N oscillator periods)
//   SYNC_STAGES_DEF     default synchronizer depth on the async oscillator input
//   TIMEOUT_CYCLES_DEF  default dead-oscillator timeout in CLK cycles
//   meter_state_t       FSM state encoding of the meter
//   sample_t            sample word shared with the downstream lp_filter
package freq_period_meter_pkg;

    localparam int unsigned DATA_BITS_DEF      = 28;
    localparam int unsigned PERIOD_BITS_DEF    = 4;
    localparam int unsigned SYNC_STAGES_DEF    = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd1 << 20;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    typedef logic [DATA_BITS_DEF-1:0] sample_t;

    // True when a counter of 'bits' width can actually reach 'timeout'.
    function automatic bit timeout_reachable(input int unsigned timeout,
                                             input int unsigned bits);
        return (64'(timeout) < (64'(1) << bits));
    endfunction

endpackage

// File: rtl/freq_period_meter_if.sv
// Sensor-side bundle of the period meter.
//   FREQ_IN    oscillator square wave (asynchronous to the meter clock)
//   OUT_VALUE  CLK cycles spanned by the last window
//   OUT_CE     one-cycle strobe, OUT_VALUE updated
//   NO_SIGNAL  oscillator considered dead
// master: the meter (consumes FREQ_IN, produces the sample outputs)
// slave:  the environment (drives FREQ_IN, consumes samples)
interface freq_period_meter_if
    import freq_period_meter_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
);

    logic                 FREQ_IN;
    logic [DATA_BITS-1:0] OUT_VALUE;
    logic                 OUT_CE;
    logic                 NO_SIGNAL;

    modport master (
        input  FREQ_IN,
        output OUT_VALUE,
        output OUT_CE,
        output NO_SIGNAL
    );

    modport slave (
        output FREQ_IN,
        input  OUT_VALUE,
        input  OUT_CE,
        input  NO_SIGNAL
    );

endinterface

// File: rtl/freq_period_meter_sync_edge_detect.sv
// Synchronizer plus rising-edge pulse for an asynchronous input.
// Reusable for any slow async sensor line.
//   clk         sampling clock
//   reset       synchronous active-high reset (clears all flops)
//   async_in    asynchronous input
//   edge_pulse  registered one-cycle pulse per detected rising edge
// The pin-to-pulse latency is a fixed SYNC_STAGES+1 cycles for every edge,
// so it cancels when two edges are subtracted.
module freq_period_meter_sync_edge_detect
    import freq_period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              edge_q;

    // Synchronizer chain, delayed copy and registered edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
            edge_q <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/freq_period_meter.sv
// Oscillator period meter: counts CLK cycles across 2^PERIOD_BITS rising edges
// of FREQ_IN with no dead time between windows, one sample + strobe per window.
//   CLK    system clock, rising edge
//   RESET  synchronous active-high reset
//   bus    master side of freq_period_meter_if
//          (FREQ_IN in; OUT_VALUE, OUT_CE, NO_SIGNAL out, all registered)
module freq_period_meter
    import freq_period_meter_pkg::*;
#(
    parameter int unsigned DATA_BITS      = DATA_BITS_DEF,
    parameter int unsigned PERIOD_BITS    = PERIOD_BITS_DEF,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    freq_period_meter_if.master bus
);

    // A zero-width edge counter is not legal; PERIOD_BITS=0 closes on every edge.
    localparam int unsigned EDGE_W = (PERIOD_BITS == 0) ? 1 : PERIOD_BITS;

    localparam logic [DATA_BITS-1:0] CNT_MAX     = '1;
    localparam logic [DATA_BITS-1:0] CNT_ONE     = DATA_BITS'(1);
    localparam logic [EDGE_W-1:0]    EDGE_LAST   = '1;
    localparam logic [EDGE_W-1:0]    EDGE_ONE    = EDGE_W'(1);
    localparam bit                   TIMEOUT_EN  = timeout_reachable(TIMEOUT_CYCLES, DATA_BITS);
    localparam logic [DATA_BITS-1:0] TIMEOUT_VAL = DATA_BITS'(TIMEOUT_CYCLES);

    meter_state_t         state_q;
    logic [DATA_BITS-1:0] cnt_q;
    logic [EDGE_W-1:0]    edge_cnt_q;
    logic [DATA_BITS-1:0] out_value_q;
    logic                 out_ce_q;
    logic                 no_signal_q;

    logic                 edge_pulse;
    logic [DATA_BITS-1:0] cnt_inc_c;
    logic                 window_close_c;
    logic                 timeout_hit_c;

    freq_period_meter_sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (CLK),
        .reset      (RESET),
        .async_in   (bus.FREQ_IN),
        .edge_pulse (edge_pulse)
    );

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // The edge that wraps edge_cnt back to zero closes the window.
    assign window_close_c = (PERIOD_BITS == 0) || (edge_cnt_q == EDGE_LAST);

    // Timeout is only meaningful if the counter can represent it.
    assign timeout_hit_c = TIMEOUT_EN && (cnt_q == TIMEOUT_VAL);

    // Meter FSM with counters and output registers.
    // The window-close edge also opens the next window (cnt restarts at 1),
    // so consecutive samples tile time without gaps. An edge on the timeout
    // cycle takes the normal path.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            edge_cnt_q  <= '0;
            out_value_q <= '0;
            out_ce_q    <= 1'b0;
            no_signal_q <= 1'b1;
        end else begin
            out_ce_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (edge_pulse) begin
                        cnt_q      <= CNT_ONE;
                        edge_cnt_q <= '0;
                        state_q    <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_pulse) begin
                        edge_cnt_q <= edge_cnt_q + EDGE_ONE;
                        if (window_close_c) begin
                            out_value_q <= cnt_q;
                            out_ce_q    <= 1'b1;
                            no_signal_q <= 1'b0;
                            cnt_q       <= CNT_ONE;
                        end else begin
                            cnt_q <= cnt_inc_c;
                        end
                    end else if (timeout_hit_c) begin
                        out_value_q <= CNT_MAX;
                        out_ce_q    <= 1'b1;
                        no_signal_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_inc_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.OUT_VALUE = out_value_q;
    assign bus.OUT_CE    = out_ce_q;
    assign bus.NO_SIGNAL = no_signal_q;

endmodule
